// File: rtl/add_sched_8b.sv
// rtl/add_sched_8b.sv - round-robin scheduler sharing one byte-serial 8-bit adder among NREQ requesters
module fwd_adder_8b (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
endmodule

module add_sched_8b #(
   parameter int NREQ  = 4,
   parameter int WORDS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*8*WORDS-1:0]   req_a,
   input  logic [NREQ*8*WORDS-1:0]   req_b,
   input  logic [NREQ-1:0]           req_cin,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [$clog2(NREQ)-1:0]   rsp_id,
   output logic [8*WORDS-1:0]        rsp_sum,
   output logic                      rsp_cout
);
   localparam int W  = 8 * WORDS;
   localparam int IW = $clog2(NREQ);
   localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, gnt_q, gnt;
   logic            gnt_any;
   logic [KW-1:0]   k_q;
   logic            carry_q;
   logic [W-1:0]    a_q, b_q;
   logic [7:0]      add_sum;
   logic            add_cout;
   logic            last_byte;

   // Search starts one past the last grant so every waiting requester gets a turn.
   always_comb begin
      gnt     = '0;
      gnt_any = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         if (!gnt_any && req_valid[(int'(ptr_q) + i) % NREQ]) begin
            gnt_any = 1'b1;
            gnt     = IW'((int'(ptr_q) + i) % NREQ);
         end
      end
   end

   // Gated by rst_n so the ready lines read zero while reset is held.
   always_comb begin
      req_ready = '0;
      if (rst_n && state_q == IDLE && gnt_any)
         req_ready[gnt] = 1'b1;
   end

   assign last_byte = (k_q == KW'(WORDS - 1));
   assign rsp_valid = (state_q == DONE);

   fwd_adder_8b u_adder (
      .a    (a_q[int'(k_q)*8 +: 8]),
      .b    (b_q[int'(k_q)*8 +: 8]),
      .cin  (carry_q),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (gnt_any) state_d = RUN;
         RUN:     if (last_byte) state_d = DONE;
         DONE:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= IW'(NREQ - 1);
         gnt_q    <= '0;
         k_q      <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         rsp_sum  <= '0;
         rsp_cout <= 1'b0;
         rsp_id   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (gnt_any) begin
                  a_q     <= req_a[int'(gnt)*W +: W];
                  b_q     <= req_b[int'(gnt)*W +: W];
                  carry_q <= req_cin[gnt];
                  ptr_q   <= gnt;
                  gnt_q   <= gnt;
                  k_q     <= '0;
               end
            end
            RUN: begin
               rsp_sum[int'(k_q)*8 +: 8] <= add_sum;
               carry_q <= add_cout;
               if (last_byte) begin
                  k_q      <= '0;
                  rsp_cout <= add_cout;
                  rsp_id   <= gnt_q;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_add_sched_8b.sv
// tb/tb_add_sched_8b.sv - self-checking bench for add_sched_8b
module tb_add_sched_8b;
   localparam int NREQ  = 4;
   localparam int WORDS = 4;
   localparam int W     = 8 * WORDS;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  rst_n, rrst_n;
   logic [NREQ-1:0]       req_valid, req_ready, req_cin;
   logic [NREQ*W-1:0]     req_a, req_b;
   logic                  rsp_valid, rsp_ready, rsp_cout;
   logic [1:0]            rsp_id;
   logic [W-1:0]          rsp_sum;

   int checks = 0;
   int errors = 0;

   add_sched_8b #(.NREQ(NREQ), .WORDS(WORDS)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic cin);
      return {1'b0, a} + {1'b0, b} + {32'd0, cin};
   endfunction

   task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic cin);
      req_a[id*W +: W] = a;
      req_b[id*W +: W] = b;
      req_cin[id]      = cin;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_rsp(input string name);
      int n;
      n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
      if (!rsp_valid) check(name, 0, 1);
   endtask

   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] sum;
      logic        cout;
   } vec_t;

   vec_t tbl[7];

   // Random regression at WORDS=4 and WORDS=1 on private instances.
   for (genvar gi = 0; gi < 2; gi++) begin : g_rand
      localparam int RW = (gi == 0) ? 4 : 1;
      localparam int RB = 8 * RW;

      logic [NREQ-1:0]    r_valid, r_ready, r_cin;
      logic [NREQ*RB-1:0] r_a, r_b;
      logic               r_rsp_valid, r_rsp_ready, r_cout;
      logic [1:0]         r_id;
      logic [RB-1:0]      r_sum;
      bit                 rdone = 1'b0;

      add_sched_8b #(.NREQ(NREQ), .WORDS(RW)) u_dut (
         .clk(clk), .rst_n(rrst_n), .req_valid(r_valid), .req_ready(r_ready),
         .req_a(r_a), .req_b(r_b), .req_cin(r_cin), .rsp_valid(r_rsp_valid),
         .rsp_ready(r_rsp_ready), .rsp_id(r_id), .rsp_sum(r_sum), .rsp_cout(r_cout)
      );

      initial begin : drive
         logic [RB-1:0] qa[NREQ];
         logic [RB-1:0] qb[NREQ];
         logic          qc[NREQ];
         int            waitc[NREQ];
         logic [RB:0]   exp_res;
         logic [1:0]    exp_id;
         int            ops, acc, g;
         bit            busy;
         r_valid = '0; r_a = '0; r_b = '0; r_cin = '0; r_rsp_ready = 1'b0;
         ops = 0; acc = -1; busy = 1'b0; exp_res = '0; exp_id = '0;
         for (int i = 0; i < NREQ; i++) waitc[i] = 0;
         wait (rrst_n === 1'b1);
         for (int cyc = 0; cyc < 30000 && ops < 1000; cyc++) begin
            @(posedge clk);
            #1;
            if (acc >= 0) r_valid[acc] = 1'b0;
            acc = -1;
            for (int i = 0; i < NREQ; i++) begin
               if (!r_valid[i] && $urandom_range(0, 2) == 0) begin
                  qa[i] = RB'($urandom);
                  qb[i] = RB'($urandom);
                  if ($urandom_range(0, 7) == 0) qa[i] = '1;
                  qc[i] = 1'($urandom_range(0, 1));
                  r_a[i*RB +: RB] = qa[i];
                  r_b[i*RB +: RB] = qb[i];
                  r_cin[i]        = qc[i];
                  r_valid[i]      = 1'b1;
                  waitc[i]        = 0;
               end
            end
            r_rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (r_ready != '0) begin
               g = 0;
               for (int i = NREQ - 1; i >= 0; i--) if (r_ready[i]) g = i;
               check("rand_onehot", 64'(r_ready & (r_ready - 1'b1)), 0);
               check("rand_grant_valid", 64'(r_valid[g]), 1);
               check("rand_accept_busy", 64'(busy), 0);
               check("rand_fair", 64'(waitc[g] < NREQ), 1);
               for (int i = 0; i < NREQ; i++) if (i != g && r_valid[i]) waitc[i]++;
               waitc[g] = 0;
               exp_res = {1'b0, qa[g]} + {1'b0, qb[g]} + {{RB{1'b0}}, qc[g]};
               exp_id  = 2'(g);
               busy    = 1'b1;
               acc     = g;
            end
            if (r_rsp_valid && r_rsp_ready) begin
               check("rand_rsp_busy", 64'(busy), 1);
               check("rand_rsp", 64'({r_id, r_cout, r_sum}), 64'({exp_id, exp_res}));
               busy = 1'b0;
               ops++;
            end
         end
         check("rand_ops", 64'(ops), 1000);
         rdone = 1'b1;
      end
   end

   initial begin
      logic [31:0] oa[NREQ];
      logic [31:0] ob[NREQ];
      logic        oc[NREQ];
      logic [32:0] r;
      int          exp_order[6];
      int          gn, rn, last_acc, g, n;

      tbl[0] = '{0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
      tbl[1] = '{0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
      tbl[2] = '{1, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
      tbl[3] = '{2, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
      tbl[4] = '{3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
      tbl[5] = '{1, 32'h00FF00FF, 32'h00010001, 1'b1, 32'h01000101, 1'b0};
      tbl[6] = '{2, 32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0};
      exp_order = '{0, 1, 2, 3, 0, 1};

      rst_n = 1'b0; rrst_n = 1'b0;
      req_valid = 4'b0001; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b1;
      #1;
      check("rst_req_ready", 64'(req_ready), 0);
      check("rst_rsp_valid", 64'(rsp_valid), 0);
      check("rst_rsp_id", 64'(rsp_id), 0);
      check("rst_rsp_sum", 64'(rsp_sum), 0);
      check("rst_rsp_cout", 64'(rsp_cout), 0);
      req_valid = '0;
      repeat (3) tick();
      rst_n = 1'b1; rrst_n = 1'b1;
      tick();

      // Single-requester vectors, including the full ripple case.
      for (int v = 0; v < 7; v++) begin
         set_req(tbl[v].id, tbl[v].a, tbl[v].b, tbl[v].cin);
         req_valid = 4'(1 << tbl[v].id);
         #1;
         check("tbl_ready", 64'(req_ready), 64'(1 << tbl[v].id));
         tick();
         req_valid = '0;
         check("tbl_ready_run", 64'(req_ready), 0);
         n = 0;
         while (!rsp_valid && n < 20) begin
            tick();
            n++;
         end
         check("tbl_latency", 64'(n), WORDS);
         check("tbl_sum", 64'(rsp_sum), 64'(tbl[v].sum));
         check("tbl_cout", 64'(rsp_cout), 64'(tbl[v].cout));
         check("tbl_id", 64'(rsp_id), 64'(tbl[v].id));
         tick();
      end

      // All requesters saturating: rotation order and accept spacing.
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         oa[i] = $urandom; ob[i] = $urandom; oc[i] = 1'(i & 1);
         set_req(i, oa[i], ob[i], oc[i]);
      end
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      gn = 0; rn = 0; last_acc = 0;
      #1;
      for (int cyc = 0; cyc < 60 && rn < 6; cyc++) begin
         if (req_ready != '0 && gn < 6) begin
            g = 0;
            for (int i = NREQ - 1; i >= 0; i--) if (req_ready[i]) g = i;
            check("rr_order", 64'(g), 64'(exp_order[gn]));
            if (gn > 0) check("rr_spacing", 64'(cyc - last_acc), 6);
            last_acc = cyc;
            gn++;
         end
         if (rsp_valid && rsp_ready && rn < 6) begin
            r = ref_add(oa[exp_order[rn]], ob[exp_order[rn]], oc[exp_order[rn]]);
            check("rr_rsp_id", 64'(rsp_id), 64'(exp_order[rn]));
            check("rr_rsp", 64'({rsp_cout, rsp_sum}), 64'(r));
            rn++;
         end
         if (rn < 6) tick();
      end
      check("rr_grants", 64'(gn), 6);
      check("rr_rsps", 64'(rn), 6);
      req_valid = '0;
      tick();

      // Response backpressure with requester 2 waiting.
      do_reset();
      set_req(0, 32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0);
      set_req(2, 32'h00001234, 32'h0000FFFF, 1'b1);
      rsp_ready = 1'b0;
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      wait_rsp("bp_timeout");
      req_valid = 4'b0100;
      r = ref_add(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0);
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", 64'(rsp_valid), 1);
         check("bp_rsp", 64'({rsp_id, rsp_cout, rsp_sum}), 64'({2'd0, r}));
         check("bp_ready", 64'(req_ready), 0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      check("bp_accept", 64'(req_ready), 64'(4'b0100));
      tick();
      req_valid = '0;
      wait_rsp("bp2_timeout");
      r = ref_add(32'h00001234, 32'h0000FFFF, 1'b1);
      check("bp2_rsp", 64'({rsp_id, rsp_cout, rsp_sum}), 64'({2'd2, r}));
      tick();

      // Reset while requester 3 is in byte 2 of its run.
      do_reset();
      set_req(3, 32'h11223344, 32'h55667788, 1'b1);
      set_req(1, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1);
      req_valid = 4'b1000;
      #1;
      check("mr_ready3", 64'(req_ready), 64'(4'b1000));
      tick();
      req_valid = 4'b1010;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_outputs", 64'({req_ready, rsp_valid, rsp_id, rsp_cout, rsp_sum}), 0);
      #3;
      rst_n = 1'b1;
      #1;
      check("mr_regrant", 64'(req_ready), 64'(4'b0010));
      tick();
      req_valid = '0;
      wait_rsp("mr_timeout");
      r = ref_add(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1);
      check("mr_rsp", 64'({rsp_id, rsp_cout, rsp_sum}), 64'({2'd1, r}));
      tick();

      for (int t = 0; t < 40000 && !(g_rand[0].rdone && g_rand[1].rdone); t++) @(posedge clk);
      check("rand_done", 64'({g_rand[0].rdone, g_rand[1].rdone}), 64'(2'b11));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/add_sched_8b.md
# add_sched_8b

Round-robin scheduler that shares a single `fwd_adder_8b` instance among `NREQ` requesters and sequences it byte-serially, so operands `8*WORDS` bits wide are added one byte per cycle with the carry chained through a register. Each requester issues its operands through a valid/ready handshake. Results return on one shared response channel tagged with the requester index. The scheduler sits between the operand sources and the one 8-bit adder datapath, and contains the only adder instance.

## Interface

Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `WORDS`, default 4: operand width in bytes, 1..8; operand width W = 8*WORDS.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `req_valid`  in  NREQ: request present, one bit per requester.
- `req_ready`  out  NREQ: request accepted this cycle, one-hot or zero.
- `req_a`  in  NREQ*W: operand A; requester i occupies bits [i*W +: W].
- `req_b`  in  NREQ*W: operand B, packed the same way as `req_a`.
- `req_cin`  in  NREQ: carry-in, one bit per requester.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: response consumer accepts the result.
- `rsp_id`  out  clog2(NREQ): index of the requester that owns the result.
- `rsp_sum`  out  W: sum, computed as (A + B + cin) mod 2^W.
- `rsp_cout`  out  1: carry out of the most significant byte.

## Operation

- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - If any `req_valid` bit is high, choose the grant g by round-robin. The search starts at `ptr`+1 mod NREQ and picks the first index whose valid bit is high.
  - `req_ready[g]` is high for that cycle; this is combinational from `req_valid`, `ptr` and the state.
  - On the clock edge: latch `req_a[g]`, `req_b[g]` and `req_cin[g]`; set `ptr` to g; set the byte index k to 0; set the carry register to `req_cin[g]`; go to RUN.
  - With no request pending, stay in IDLE.
- RUN:
  - The adder inputs are byte k of A, byte k of B, and the carry register.
  - On each edge: store `add_sum` into `rsp_sum[8k +: 8]`; store `add_cout` into the carry register; increment k.
  - When k == WORDS-1, write `rsp_cout` from `add_cout`, write `rsp_id` as g, and go to DONE.
- DONE:
  - `rsp_valid` is high.
  - `rsp_sum`, `rsp_cout` and `rsp_id` stay stable until `rsp_valid` && `rsp_ready`; on that edge go to IDLE.
  - All `req_ready` bits are low.
- Requests are accepted only in IDLE. `req_ready` is all zero in RUN and DONE.
- Requesters must hold valid and operands stable until ready. Only the granted requester's operands are sampled, and only on the accept edge.
- Fairness: a requester that holds `req_valid` is granted within NREQ accepts.
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_sum` = 0, `rsp_cout` = 0.
  - State = IDLE, `ptr` = NREQ-1 (requester 0 wins first), k = 0, carry register = 0.
- Reset mid-operation: all registers clear immediately without waiting for a clock edge. The in-flight operation is dropped and no response is produced for it. After `rst_n` rises, pending requests are re-arbitrated from the reset pointer.
- Simultaneous `rsp_ready` and new `req_valid` in DONE: the response completes, and the new request is accepted on the following IDLE cycle.
- WORDS = 1: RUN lasts one cycle.

## Timing

- Accept at edge T (the IDLE cycle in which `req_ready` is high).
- RUN occupies cycles T+1 .. T+WORDS.
- `rsp_valid` rises in cycle T+WORDS+1. Latency from accept to response is WORDS+1 cycles.
- Minimum accept-to-accept spacing is WORDS+2 cycles: one IDLE cycle, WORDS RUN cycles, and at least one DONE cycle.
- No combinational path exists from `rsp_ready` to any output.

## Test plan

1. Requester 0 only, WORDS=4, A=0x000000FF, B=0x00000001, cin=0:
   - `req_ready[0]` pulses for one cycle.
   - 5 cycles later: `rsp_valid`=1, `rsp_sum`=0x00000100, `rsp_cout`=0, `rsp_id`=0.
2. Full ripple: A=0xFFFFFFFF, B=0x00000000, cin=1 → `rsp_sum`=0x00000000, `rsp_cout`=1.
3. All four requesters hold valid continuously with distinct operands, `rsp_ready`=1:
   - Grant order is 0,1,2,3,0,1.
   - Each `rsp_id` matches its grant, and sums are correct.
   - Accepts are spaced exactly 6 cycles apart.
4. Backpressure: `rsp_ready` held at 0 for 10 cycles while requester 2 is pending:
   - `rsp_valid` stays 1, and `rsp_sum`/`rsp_id` stay stable.
   - `req_ready` stays 0.
   - Requester 2 is accepted 1 cycle after the handshake completes.
5. Assert `rst_n` low during RUN (k=2) while requester 3 is being served:
   - All outputs read 0 immediately, and no response is emitted for the dropped operation.
   - After release, with requesters 1 and 3 pending, requester 1 is granted first.
6. Random regression, 1000 operations at WORDS=1 and WORDS=4, random valid patterns and `rsp_ready` stalls:
   - Every response matches the model (A+B+cin) mod 2^W and its carry.
   - No requester waits more than NREQ grants.
